adder_cmd_initiator: RTL and testbench

//  Bus-master front end for the 8-bit adder/register responder. Accepts one command
//  at a time (register write, register read, add) on a valid/ready port and

---
 rtl/adder_cmd_initiator.sv | 127 ++++++++++++
 tb/tb_adder_cmd_initiator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/adder_cmd_initiator.sv
// adder_cmd_initiator: valid/ready command front end sequencing the adder responder's register and operand buses.
// Optional INIT_SUM_CHECK_EN adds shadow control/offset registers and flags sums that disagree with them.
module adder_cmd_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int NUM_REGS = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_err,
  output logic       rsp_mismatch,
  output logic [2:0] Des_address,
  output logic [7:0] Des_value,
  output logic       Des_reg_valid,
  output logic       Des_wr_rd,
  output logic [7:0] Value_a,
  output logic [7:0] Value_b,
  output logic       Data_val,
  input  logic [7:0] Des_rd_value,
  input  logic [7:0] Sum_result,
  input  logic       Sum_carry,
  input  logic       Data_ready
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] NR = NUM_REGS[3:0];
  typedef enum logic [2:0] {IDLE, REG_WR, REG_RD, RD_WAIT, ADD, ADD_WAIT, RSP} state_t;
  state_t state, next;
  logic [2:0] addr;
  logic [7:0] wdata, a, b, data_q;
  logic carry_q, err_q, bad, accept, timeout;
  logic [CW-1:0] cnt;
  assign accept = state == IDLE && cmd_valid;
  assign bad = cmd_op == 2'b11 || (!cmd_op[1] && {1'b0, cmd_addr} >= NR);
  assign timeout = cnt == TO_LAST;
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = !cmd_valid ? IDLE : bad ? RSP : cmd_op == 2'b00 ? REG_WR : cmd_op == 2'b01 ? REG_RD : ADD;
      REG_WR:   next = RSP;
      REG_RD:   next = RD_WAIT;
      RD_WAIT:  next = RSP;
      ADD:      next = ADD_WAIT;
      ADD_WAIT: next = (Data_ready || timeout) ? RSP : ADD_WAIT;
      RSP:      next = rsp_ready ? IDLE : RSP;
      default:  next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      addr <= '0;
      wdata <= '0;
      a <= '0;
      b <= '0;
      data_q <= '0;
      carry_q <= 1'b0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      state <= next;
      if (accept) begin
        addr <= cmd_addr;
        wdata <= cmd_wdata;
        a <= cmd_a;
        b <= cmd_b;
        data_q <= (!bad && cmd_op == 2'b00) ? cmd_wdata : 8'h00;
        carry_q <= 1'b0;
        err_q <= bad;
      end
      if (state == RD_WAIT) data_q <= Des_rd_value;
      if (state == ADD) cnt <= '0;
      if (state == ADD_WAIT) begin
        if (Data_ready) begin
          data_q <= Sum_result;
          carry_q <= Sum_carry;
        end else if (timeout) err_q <= 1'b1;
        else cnt <= cnt + 1'b1;
      end
    end
  end
`ifdef INIT_SUM_CHECK_EN
  logic ctrl0, mm_q;
  logic [7:0] offset;
  logic [8:0] s1, s2, expect_sum;
  assign s1 = {1'b0, a} + {1'b0, b};
  assign s2 = {1'b0, s1[7:0]} + {1'b0, offset} + {8'h00, s1[8]};
  assign expect_sum = ctrl0 ? s2 : s1;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl0 <= 1'b0;
      offset <= '0;
      mm_q <= 1'b0;
    end else begin
      if (state == REG_WR && addr == 3'd0) ctrl0 <= wdata[0];
      if (state == REG_WR && addr == 3'd1) offset <= wdata;
      if (accept) mm_q <= 1'b0;
      if (state == ADD_WAIT && Data_ready) mm_q <= {Sum_carry, Sum_result} != expect_sum;
    end
  end
  assign rsp_mismatch = rsp_valid && mm_q;
`else
  assign rsp_mismatch = 1'b0;
`endif
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RSP;
  assign rsp_data = rsp_valid ? data_q : 8'h00;
  assign rsp_carry = rsp_valid && carry_q;
  assign rsp_err = rsp_valid && err_q;
  assign Des_reg_valid = state == REG_WR || state == REG_RD;
  assign Des_wr_rd = state == REG_WR;
  assign Des_address = Des_reg_valid ? addr : 3'd0;
  assign Des_value = Des_wr_rd ? wdata : 8'h00;
  assign Data_val = state == ADD;
  assign Value_a = Data_val ? a : 8'h00;
  assign Value_b = Data_val ? b : 8'h00;
endmodule

// File: tb/tb_adder_cmd_initiator.sv
// tb_adder_cmd_initiator: directed table, random commands against a reference model, timeout/backpressure/reset sequences.
module tb_adder_cmd_initiator;
  logic clk = 0, reset_n = 0;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0;
  logic [1:0] cmd_op = 0;
  logic [2:0] cmd_addr = 0, Des_address;
  logic [7:0] cmd_wdata = 0, cmd_a = 0, cmd_b = 0, rsp_data, Des_value, Value_a, Value_b;
  logic rsp_carry, rsp_err, rsp_mismatch, Des_reg_valid, Des_wr_rd, Data_val;
  logic [7:0] Des_rd_value = 0, Sum_result = 0;
  logic Sum_carry = 0, Data_ready = 0;
  always #5 clk = ~clk;
`ifdef INIT_SUM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  adder_cmd_initiator dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .rsp_mismatch(rsp_mismatch), .Des_address(Des_address), .Des_value(Des_value),
    .Des_reg_valid(Des_reg_valid), .Des_wr_rd(Des_wr_rd), .Value_a(Value_a), .Value_b(Value_b),
    .Data_val(Data_val), .Des_rd_value(Des_rd_value), .Sum_result(Sum_result), .Sum_carry(Sum_carry),
    .Data_ready(Data_ready)
  );

  // Responder: register file, read data one cycle after the strobe, sum ready one cycle after Data_val.
  logic stall = 0, corrupt = 0;
  logic [7:0] rregs [0:7] = '{default: 8'h00};
  int rv_cnt = 0, dv_cnt = 0, overlap = 0;
  function automatic logic [8:0] resp_sum(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (rregs[0][0]) s = {1'b0, s[7:0]} + {1'b0, rregs[1]} + {8'h00, s[8]};
    return s;
  endfunction
  always @(posedge clk) begin
    if (Des_reg_valid && Des_wr_rd) rregs[Des_address] <= Des_value;
    Des_rd_value <= (Des_reg_valid && !Des_wr_rd) ? rregs[Des_address] : 8'h00;
    Data_ready <= Data_val && !Des_reg_valid && !stall;
    if (Data_val) {Sum_carry, Sum_result} <= resp_sum(Value_a, Value_b) ^ {8'h00, corrupt};
    if (Des_reg_valid) rv_cnt <= rv_cnt + 1;
    if (Data_val) dv_cnt <= dv_cnt + 1;
    if (Des_reg_valid && Data_val) overlap <= overlap + 1;
  end

  int vectors = 0, miscompares = 0;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: spec-level register map and arithmetic.
  logic [7:0] mregs [0:2] = '{default: 8'h00};
  task automatic model(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] wd, a, b,
                       output logic [7:0] d, output logic c, e, output int rv, dv);
    int t;
    d = 0; c = 0; e = 0; rv = 0; dv = 0;
    if (op == 3 || (op < 2 && addr >= 3)) e = 1;
    else if (op == 0) begin mregs[addr] = wd; d = wd; rv = 1; end
    else if (op == 1) begin d = mregs[addr]; rv = 1; end
    else begin
      t = int'(a) + int'(b);
      if (mregs[0][0]) t = t % 256 + int'(mregs[1]) + t / 256;
      d = 8'(t % 256); c = t >= 256; dv = 1;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] wd, a, b,
                         output logic [7:0] d, output logic c, e, m, output int lat, rv, dv);
    int rv0, dv0;
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_a = a; cmd_b = b;
    cmd_valid = 1; rsp_ready = 1;
    rv0 = rv_cnt; dv0 = dv_cnt;
    @(posedge clk);
    #1 cmd_valid = 0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    if (lat >= 100) check("rsp_wait_bound", 0, 1);
    d = rsp_data; c = rsp_carry; e = rsp_err; m = rsp_mismatch;
    @(posedge clk);
    #1 rv = rv_cnt - rv0; dv = dv_cnt - dv0;
  endtask

  typedef struct {
    logic [1:0] op; logic [2:0] addr; logic [7:0] wd, a, b, d; logic c, e; int lat, rv, dv;
  } vec_t;
  vec_t tbl [12];

  initial begin
    logic [7:0] d, ed, hd;
    logic c, e, m, ec, ee;
    int lat, rv, dv, erv, edv, seen;
    tbl[0]  = '{2'd0, 3'd1, 8'h05, 8'h00, 8'h00, 8'h05, 1'b0, 1'b0, 2, 1, 0};
    tbl[1]  = '{2'd1, 3'd1, 8'h00, 8'h00, 8'h00, 8'h05, 1'b0, 1'b0, 3, 1, 0};
    tbl[2]  = '{2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2, 1, 0};
    tbl[3]  = '{2'd2, 3'd0, 8'h00, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 3, 0, 1};
    tbl[4]  = '{2'd0, 3'd0, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 2, 1, 0};
    tbl[5]  = '{2'd0, 3'd1, 8'h03, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 2, 1, 0};
    tbl[6]  = '{2'd2, 3'd0, 8'h00, 8'h01, 8'h02, 8'h06, 1'b0, 1'b0, 3, 0, 1};
    tbl[7]  = '{2'd1, 3'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1, 0, 0};
    tbl[8]  = '{2'd3, 3'd0, 8'h55, 8'h11, 8'h22, 8'h00, 1'b0, 1'b1, 1, 0, 0};
    tbl[9]  = '{2'd0, 3'd5, 8'hAA, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1, 0, 0};
    tbl[10] = '{2'd1, 3'd0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 3, 1, 0};
    tbl[11] = '{2'd2, 3'd0, 8'h00, 8'hFF, 8'hFF, 8'h02, 1'b1, 1'b0, 3, 0, 1};
    repeat (2) @(posedge clk);
    #1 check("reset_cmd_ready", cmd_ready, 1);
    check("reset_outputs", {rsp_valid, rsp_data, rsp_carry, rsp_err, rsp_mismatch, Des_address, Des_value,
                            Des_reg_valid, Des_wr_rd, Value_a, Value_b, Data_val}, 0);
    @(negedge clk) reset_n = 1;
    foreach (tbl[i]) begin
      model(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].a, tbl[i].b, ed, ec, ee, erv, edv);
      run_cmd(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].a, tbl[i].b, d, c, e, m, lat, rv, dv);
      check($sformatf("tbl%0d_data", i), d, tbl[i].d);
      check($sformatf("tbl%0d_carry", i), c, tbl[i].c);
      check($sformatf("tbl%0d_err", i), e, tbl[i].e);
      check($sformatf("tbl%0d_mismatch", i), m, 0);
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("tbl%0d_reg_strobes", i), rv, tbl[i].rv);
      check($sformatf("tbl%0d_add_strobes", i), dv, tbl[i].dv);
    end
    for (int i = 0; i < 150; i++) begin
      logic [1:0] op; logic [2:0] addr; logic [7:0] wd, a, b;
      op = 2'($urandom_range(0, 3)); addr = 3'($urandom_range(0, 4));
      wd = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
      model(op, addr, wd, a, b, ed, ec, ee, erv, edv);
      run_cmd(op, addr, wd, a, b, d, c, e, m, lat, rv, dv);
      check($sformatf("rnd%0d_data", i), d, ed);
      check($sformatf("rnd%0d_carry", i), c, ec);
      check($sformatf("rnd%0d_err", i), e, ee);
      check($sformatf("rnd%0d_mismatch", i), m, 0);
      check($sformatf("rnd%0d_strobes", i), {rv[7:0], dv[7:0]}, {erv[7:0], edv[7:0]});
    end
    // Responder never answers; response then held under backpressure.
    stall = 1;
    @(negedge clk);
    cmd_op = 2; cmd_a = 8'h12; cmd_b = 8'h34; cmd_valid = 1; rsp_ready = 0;
    @(posedge clk);
    #1 cmd_valid = 0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    check("timeout_latency", lat, 18);
    check("timeout_fields", {rsp_err, rsp_carry, rsp_mismatch, rsp_data}, {3'b100, 8'h00});
    hd = rsp_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d", k), {rsp_valid, rsp_err, rsp_carry, cmd_ready, rsp_data}, {4'b1100, hd});
    end
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    check("hold_release", {rsp_valid, cmd_ready}, 2'b01);
    stall = 0;
    // Corrupted sum is only flagged when the self-check is built in.
    corrupt = 1;
    model(2, 0, 0, 8'h01, 8'h02, ed, ec, ee, erv, edv);
    run_cmd(2, 0, 0, 8'h01, 8'h02, d, c, e, m, lat, rv, dv);
    check("corrupt_sum", {c, d}, {ec, ed} ^ 9'h001);
    check("corrupt_mismatch", m, CHK);
    corrupt = 0;
    // Reset during ADD_WAIT aborts without a response.
    stall = 1;
    @(negedge clk);
    cmd_op = 2; cmd_a = 8'h07; cmd_b = 8'h08; cmd_valid = 1;
    @(posedge clk);
    #1 cmd_valid = 0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", cmd_ready, 0);
    reset_n = 0;
    @(posedge clk);
    #1 check("midreset_cmd_ready", cmd_ready, 1);
    check("midreset_outputs", {rsp_valid, rsp_data, rsp_carry, rsp_err, rsp_mismatch, Des_address, Des_value,
                               Des_reg_valid, Des_wr_rd, Value_a, Value_b, Data_val}, 0);
    @(negedge clk) reset_n = 1;
    stall = 0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no_rsp_after_abort", seen, 0);
    check("bus_overlap_cycles", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
